digest_reader: RTL and testbench

Drains a finished SHA-256 chaining state (H0..H7) from the hash core and streams it out as eight 32-bit words over a valid/ready handshake. It also registers a difficulty flag computed from the captured digest. It sits downstream of the eight chaining-value registers, on the read side, and feeds the result/UART path. It holds one digest at a time and reports digests it cannot accept.

---
 rtl/digest_reader.sv | 120 ++++++++++++
 tb/tb_digest_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/digest_reader.sv
// digest_reader: captures a final SHA-256 chaining state (H0..H7) and streams
// it out as eight 32-bit words over valid/ready, H0 first. A difficulty flag
// (hit) is registered on capture. One digest is held at a time; a digest that
// arrives while busy is dropped and flagged in a sticky overflow bit, except
// when it coincides with acceptance of the last word (back-to-back capture).
// Optional macro DIGEST_BYTE_SWAP_EN: byte-reverse each emitted word.
module digest_reader #(
  parameter int ZWORDS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] digest_in,
  input  logic         digest_valid,
  output logic [31:0]  out_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_index,
  output logic         out_last,
  output logic         busy,
  output logic         hit,
  output logic         overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0][31:0]  buf_q, buf_d;
  logic              hit_q, hit_d;
  logic              ovf_q, ovf_d;

  logic              hit_calc;
  logic              accept;
  logic              last_acc;
  logic [31:0]       word_sel;

  // Difficulty test on the incoming native words: H7 sits in bits [31:0],
  // H6 in [63:32], and so on, so the top ZWORDS words are the low bits.
  always_comb begin
    hit_calc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((i < ZWORDS) && (digest_in[32*i +: 32] != 32'h0)) hit_calc = 1'b0;
    end
  end

  assign accept   = (state_q == SEND) && out_ready;
  assign last_acc = accept && (idx_q == 3'd7);

  // Next-state logic: capture, index advance, drop/overflow handling.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    hit_d   = hit_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (digest_valid) begin
          for (int i = 0; i < 8; i++) buf_d[i] = digest_in[255-32*i -: 32];
          idx_d   = 3'd0;
          hit_d   = hit_calc;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_acc) begin
          idx_d = 3'd0;
          if (digest_valid) begin
            // Back-to-back capture: the slot frees up on this very edge.
            for (int i = 0; i < 8; i++) buf_d[i] = digest_in[255-32*i -: 32];
            hit_d   = hit_calc;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (accept) idx_d = idx_q + 3'd1;
          if (digest_valid) ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      buf_q   <= '0;
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output word is a mux of registers only; optionally byte-reversed.
  always_comb begin
    word_sel = buf_q[idx_q];
`ifdef DIGEST_BYTE_SWAP_EN
    word_sel = {word_sel[7:0], word_sel[15:8], word_sel[23:16], word_sel[31:24]};
`else
    word_sel = buf_q[idx_q];
`endif
  end

  assign out_valid = (state_q == SEND);
  assign out_word  = out_valid ? word_sel : 32'h0;
  assign out_index = idx_q;
  assign out_last  = out_valid && (idx_q == 3'd7);
  assign busy      = (state_q == SEND);
  assign hit       = hit_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_digest_reader.sv
// Scoreboard bench for digest_reader: stimulus pushes expected words, a
// negedge monitor pops and compares on every accepted word.
module tb_digest_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] digest_in;
  logic         digest_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic         out_valid;
  logic [2:0]   out_index;
  logic         out_last;
  logic         busy, hit, overflow;

  // Extra instances only to observe hit with other ZWORDS values.
  logic [31:0]  w2, w3;
  logic         v2, v3, l2, l3, b2, b3, h2, h3, o2, o3;
  logic [2:0]   i2, i3;

  always #5 clk = ~clk;

  digest_reader #(.ZWORDS(1)) dut (
    .clk(clk), .rst(rst), .digest_in(digest_in), .digest_valid(digest_valid),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .busy(busy), .hit(hit),
    .overflow(overflow));

  digest_reader #(.ZWORDS(2)) dut2 (
    .clk(clk), .rst(rst), .digest_in(digest_in), .digest_valid(digest_valid),
    .out_word(w2), .out_valid(v2), .out_ready(out_ready),
    .out_index(i2), .out_last(l2), .busy(b2), .hit(h2), .overflow(o2));

  digest_reader #(.ZWORDS(3)) dut3 (
    .clk(clk), .rst(rst), .digest_in(digest_in), .digest_valid(digest_valid),
    .out_word(w3), .out_valid(v3), .out_ready(out_ready),
    .out_index(i3), .out_last(l3), .busy(b3), .hit(h3), .overflow(o3));

  localparam logic [255:0] ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                  32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] HITD = {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafef00d,
                                   32'h12345678, 32'h00000001, 32'h00000000, 32'h00000000};

  typedef struct packed { logic [31:0] w; logic [2:0] i; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int acc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef DIGEST_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Monitor: compare accepted words in order and check stall stability.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_w;
  logic [2:0]  prev_i;
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev && out_valid) begin
        chk("stall_word", out_word, prev_w);
        chk("stall_index", {29'd0, out_index}, {29'd0, prev_i});
      end
      if (out_valid && out_ready) begin
        acc++;
        if (q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word", out_word, fmt(e.w));
          chk("index", {29'd0, out_index}, {29'd0, e.i});
          chk("last", {31'd0, out_last}, {31'd0, (e.i == 3'd7)});
        end
      end
      if (!out_valid) chk("last_idle", {31'd0, out_last}, 32'd0);
      stall_prev = out_valid && !out_ready;
      prev_w     = out_word;
      prev_i     = out_index;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic pulse(input logic [255:0] d, input bit expect_take);
    logic [255:0] dv;
    dv = d;
    digest_in    = d;
    digest_valid = 1'b1;
    if (expect_take)
      for (int i = 0; i < 8; i++) q.push_back({dv[255-32*i -: 32], 3'(i)});
    @(posedge clk); #1;
    digest_valid = 1'b0;
    digest_in    = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", q.size(), 32'd0);
  endtask

  task automatic wait_idx(input logic [2:0] k);
    int n = 0;
    while (!(out_valid && out_index == k) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idx_timeout", {31'd0, (n >= 50)}, 32'd0);
  endtask

  logic [3:0] pat = 4'b1001;

  initial begin
    int a0, n;
    rst = 1'b1; digest_valid = 1'b0; out_ready = 1'b0; digest_in = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_word", out_word, 32'd0);
    chk("rst_index", {29'd0, out_index}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic stream, ready held high.
    out_ready = 1'b1;
    a0 = acc;
    pulse(ABC, 1'b1);
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_idx0", {29'd0, out_index}, 32'd0);
    chk("basic_hit", {31'd0, hit}, 32'd0);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    repeat (7) begin @(posedge clk); #1; end
    chk("basic_last_cycle", {31'd0, out_last}, 32'd1);
    drain();
    chk("basic_count", acc - a0, 32'd8);
    chk("basic_busy_fall", {31'd0, busy}, 32'd0);

    // Backpressure with ready pattern 1,0,0,1.
    out_ready = 1'b0;
    a0 = acc;
    pulse(ABC, 1'b1);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      out_ready = pat[n % 4];
      @(posedge clk); #1;
      n++;
    end
    chk("bp_left", q.size(), 32'd0);
    chk("bp_count", acc - a0, 32'd8);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Hit with different ZWORDS.
    out_ready = 1'b0;
    pulse(HITD, 1'b1);
    chk("hit_z1", {31'd0, hit}, 32'd1);
    chk("hit_z2", {31'd0, h2}, 32'd1);
    chk("hit_z3", {31'd0, h3}, 32'd0);
    out_ready = 1'b1;
    drain();

    // Back-to-back capture on acceptance of word 7.
    pulse(ABC, 1'b1);
    wait_idx(3'd7);
    pulse(HITD, 1'b1);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_idx", {29'd0, out_index}, 32'd0);
    chk("b2b_hit", {31'd0, hit}, 32'd1);
    chk("b2b_ovf", {31'd0, overflow}, 32'd0);
    drain();
    chk("b2b_ovf_end", {31'd0, overflow}, 32'd0);

    // Overflow: digest mid-stream at index 3 is dropped.
    pulse(ABC, 1'b1);
    wait_idx(3'd3);
    pulse(HITD, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_hit_kept", {31'd0, hit}, 32'd0);
    drain();
    chk("ovf_idle", {31'd0, busy}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-stream at index 4.
    pulse(ABC, 1'b1);
    wait_idx(3'd4);
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_word", out_word, 32'd0);
    chk("mrst_index", {29'd0, out_index}, 32'd0);
    chk("mrst_last", {31'd0, out_last}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_hit", {31'd0, hit}, 32'd0);
    chk("mrst_ovf", {31'd0, overflow}, 32'd0);
    q.delete();
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    pulse(HITD, 1'b1);
    chk("mrst_fresh_idx", {29'd0, out_index}, 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
